// File: rtl/tinker_pkg.sv
// Shared types and constants for the memory port arbiter.
package tinker_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam logic [63:0] ALIGN_MASK       = 64'h7;

    function automatic logic misaligned(input logic [63:0] addr);
        return (addr & ALIGN_MASK) != 64'd0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data requesters.
// Optional anti-starvation for fetch under MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter
    import tinker_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [63:0] i_rdata,
    input  logic        flush,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("STARVE_LIMIT must be within 1..15");
    end

    owner_e owner_q, owner_d;
    logic   err_q, err_d;
    logic   st_q, st_d;
    logic   d_mis, d_slot, fetch_prio;
    logic   unused_iaddr;

    assign unused_iaddr = ^i_addr[2:0];

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;

    assign fetch_prio = i_req && (starve_q >= LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (!i_req || i_gnt) begin
            starve_d = 4'd0;
        end else if (d_gnt && starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) starve_q <= 4'd0;
        else       starve_q <= starve_d;
    end
`else
    assign fetch_prio = 1'b0;
`endif

    always_comb begin
        d_mis     = misaligned(d_addr);
        d_gnt     = 1'b0;
        i_gnt     = 1'b0;
        if (!reset) begin
            // A misaligned data access never uses the port, so fetch may share the cycle
            d_gnt = d_req && (d_mis || !fetch_prio);
            i_gnt = i_req && (!d_req || d_mis || fetch_prio);
        end
        d_slot    = d_gnt && !d_mis;
        mem_en    = d_slot || i_gnt;
        mem_we    = d_slot && d_we;
        mem_addr  = 64'd0;
        if (d_slot)     mem_addr = d_addr;
        else if (i_gnt) mem_addr = {i_addr[63:3], 3'b000};
        mem_wdata = mem_we ? d_wdata : 64'd0;
        owner_d   = OWN_NONE;
        if (d_slot)              owner_d = OWN_D;
        else if (i_gnt && !flush) owner_d = OWN_IF;
        err_d     = d_gnt && d_mis;
        st_d      = d_slot && d_we;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWN_NONE;
            err_q   <= 1'b0;
            st_q    <= 1'b0;
        end else begin
            owner_q <= owner_d;
            err_q   <= err_d;
            st_q    <= st_d;
        end
    end

    assign i_rvalid = (owner_q == OWN_IF) && !flush;
    assign i_rdata  = i_rvalid ? mem_rdata : 64'd0;
    assign d_rvalid = (owner_q == OWN_D) || err_q;
    assign d_rdata  = (owner_q == OWN_D && !st_q) ? mem_rdata : 64'd0;
    assign d_err    = err_q;

endmodule
